t_latch_arbiter: RTL and testbench

Round-robin arbiter and strobe sequencer that shares one WIDTH-bit bank of T-type storage cells between N_REQ requesters. Each requester presents a toggle mask. The block grants one requester at a time and drives a single-cycle T/En strobe into the bank. It then enforces a settle window before the next strobe and keeps a registered shadow copy of the bank contents. It sits between the request sources and the T-cell datapath, which sees only T_out and En_out.

---
 rtl/t_latch_arbiter.sv | 168 ++++++++++++++++
 tb/tb_t_latch_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_latch_arbiter.sv
// Round-robin arbiter and strobe sequencer for a shared bank of T-type cells.
// One requester at a time gets a single-cycle T/En strobe, followed by a settle window.
module t_latch_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ*WIDTH-1:0]   Mask,
    output logic [N_REQ-1:0]         Gnt,
    output logic [N_REQ-1:0]         Ack,
    output logic [WIDTH-1:0]         T_out,
    output logic                     En_out,
    output logic [WIDTH-1:0]         State_q,
    output logic                     Busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [PW-1:0]     ptr_r, ptr_next_s;
    logic [PW-1:0]     win_r, win_next_s, win_s;
    logic [WIDTH-1:0]  mask_r, mask_next_s, sel_mask_s;
    logic [CW-1:0]     cnt_r, cnt_next_s;
    logic [N_REQ-1:0]  gnt_r, gnt_next_s;
    logic [N_REQ-1:0]  ack_r, ack_next_s;
    logic [WIDTH-1:0]  t_r, t_next_s;
    logic              en_r, en_next_s;
    logic [WIDTH-1:0]  shadow_r, shadow_next_s;
    logic              busy_r, busy_next_s;

    // First requesting index at or above ptr, wrapping around.
    function automatic logic [PW-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                  input logic [PW-1:0]    ptr);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx   = (int'(ptr) + off) % N_REQ;
            sel   = (!found && req[idx]) ? PW'(idx) : sel;
            found = found | req[idx];
        end
        return sel;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] w);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
        return (int'(w) == N_REQ - 1) ? PW'(0) : PW'(int'(w) + 1);
    endfunction

    assign win_s      = pick_winner(Req, ptr_r);
    assign sel_mask_s = Mask[int'(win_s)*WIDTH +: WIDTH];

    // Next-state and next-output computation for the grant/strobe/settle sequence.
    always_comb begin
        state_next_s  = state_r;
        ptr_next_s    = ptr_r;
        win_next_s    = win_r;
        mask_next_s   = mask_r;
        cnt_next_s    = cnt_r;
        gnt_next_s    = gnt_r;
        ack_next_s    = '0;
        t_next_s      = '0;
        en_next_s     = 1'b0;
        shadow_next_s = shadow_r;
        busy_next_s   = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (|Req) begin
                    // Mask is committed here; later Req/Mask changes cannot touch this strobe.
                    win_next_s   = win_s;
                    mask_next_s  = sel_mask_s;
                    gnt_next_s   = onehot(win_s);
                    ack_next_s   = onehot(win_s);
                    t_next_s     = sel_mask_s;
                    en_next_s    = 1'b1;
                    busy_next_s  = 1'b1;
                    state_next_s = ST_STROBE;
                end else begin
                    gnt_next_s  = '0;
                    busy_next_s = 1'b0;
                end
            end
            ST_STROBE: begin
                shadow_next_s = shadow_r ^ mask_r;
                ptr_next_s    = next_ptr(win_r);
                cnt_next_s    = CW'(SETTLE);
                state_next_s  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r <= CW'(1)) begin
                    cnt_next_s   = '0;
                    gnt_next_s   = '0;
                    busy_next_s  = 1'b0;
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            default: begin
                gnt_next_s   = '0;
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_r    <= '0;
            win_r    <= '0;
            mask_r   <= '0;
            cnt_r    <= '0;
            gnt_r    <= '0;
            ack_r    <= '0;
            t_r      <= '0;
            en_r     <= 1'b0;
            shadow_r <= '0;
            busy_r   <= 1'b0;
        end else begin
            ptr_r    <= ptr_next_s;
            win_r    <= win_next_s;
            mask_r   <= mask_next_s;
            cnt_r    <= cnt_next_s;
            gnt_r    <= gnt_next_s;
            ack_r    <= ack_next_s;
            t_r      <= t_next_s;
            en_r     <= en_next_s;
            shadow_r <= shadow_next_s;
            busy_r   <= busy_next_s;
        end
    end

    assign Gnt     = gnt_r;
    assign Ack     = ack_r;
    assign T_out   = t_r;
    assign En_out  = en_r;
    assign State_q = shadow_r;
    assign Busy    = busy_r;

endmodule

// File: tb/tb_t_latch_arbiter.sv
// Randomized and directed bench for t_latch_arbiter, checked against a
// grant-window reference model (strobe cycle + settle length, no FSM).
module tb_t_latch_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ST = 2;
    localparam int OW = 2*N + 2*W + 2;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b1;
    logic [N-1:0]     Req = '0;
    logic [N*W-1:0]   Mask = '0;
    logic [N-1:0]     Gnt, Ack;
    logic [W-1:0]     T_out, State_q;
    logic             En_out, Busy;

    int vectors = 0;
    int miscompares = 0;

    t_latch_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE(ST)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Mask(Mask),
        .Gnt(Gnt), .Ack(Ack), .T_out(T_out), .En_out(En_out),
        .State_q(State_q), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Reference model: a grant occupies cycles s_cyc .. s_cyc+ST.
    int         cyc = 0;
    int         s_cyc = -1000;
    int         m_w = 0;
    int         m_ptr = 0;
    logic [W-1:0] m_mask = '0, m_shadow = '0, m_prev = '0;

    task automatic model_reset();
        s_cyc = -1000; m_w = 0; m_ptr = 0;
        m_mask = '0; m_shadow = '0; m_prev = '0;
    endtask

    function automatic logic [OW-1:0] exp_all();
        logic [N-1:0] g, a;
        logic [W-1:0] t, s;
        logic e, b;
        g = '0; a = '0; t = '0; e = 1'b0;
        if (cyc >= s_cyc && cyc <= s_cyc + ST) g[m_w] = 1'b1;
        if (cyc == s_cyc) begin a[m_w] = 1'b1; t = m_mask; e = 1'b1; end
        s = (cyc == s_cyc) ? m_prev : m_shadow;
        b = |g;
        return {g, a, t, e, s, b};
    endfunction

    // One clock: sample at posedge, update the model, return at negedge.
    task automatic tick();
        int w;
        int idx;
        @(posedge Clk);
        cyc++;
        if (!Rst_n) begin
            model_reset();
        end else if ((cyc - 1) > s_cyc + ST && Req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && Req[idx]) w = idx;
            end
            s_cyc    = cyc;
            m_w      = w;
            m_mask   = Mask[w*W +: W];
            m_prev   = m_shadow;
            m_shadow = m_shadow ^ m_mask;
            m_ptr    = (w + 1) % N;
        end
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        Req = '0;
        model_reset();
        tick();
        tick();
        Rst_n = 1'b1;
    endtask

    function automatic int oh_index(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        #1 Rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            Req = N'($urandom); Mask = $urandom;
            tick();
            vectors++;
            if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== '0) begin
                miscompares++;
                $display("FAIL reset_hold got=%h exp=0", {Gnt, Ack, T_out, En_out, State_q, Busy});
            end
        end
        Rst_n = 1'b1;
        Req = 4'b0010; Mask = 32'h0000_5A00;
        tick(); tick();
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_presettle busy got=%b exp=1", Busy);
        end
        Rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_async got=%h exp=0", {Gnt, Ack, T_out, En_out, State_q, Busy});
        end
        Req = '0;
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic test_single();
        int busy_cnt;
        for (int rep = 0; rep < 2; rep++) begin
            busy_cnt = 0;
            Req = 4'b0010;
            Mask = $urandom;
            Mask[1*W +: W] = 8'h0F;
            for (int c = 0; c < 8; c++) begin
                tick();
                vectors++;
                if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== exp_all()) begin
                    miscompares++;
                    $display("FAIL single cyc=%0d got=%h exp=%h", cyc, {Gnt, Ack, T_out, En_out, State_q, Busy}, exp_all());
                end
                if (Busy) busy_cnt++;
                if (En_out) begin
                    vectors++;
                    if ({Gnt, Ack, T_out} !== {4'b0010, 4'b0010, 8'h0F}) begin
                        miscompares++;
                        $display("FAIL single_strobe got=%h exp=%h", {Gnt, Ack, T_out}, {4'b0010, 4'b0010, 8'h0F});
                    end
                    Req = '0;
                end
                Mask[0 +: W] = W'($urandom);
            end
            vectors++;
            if (busy_cnt != 3) begin
                miscompares++;
                $display("FAIL single_busy got=%0d exp=3", busy_cnt);
            end
            vectors++;
            if (State_q !== ((rep == 0) ? 8'h0F : 8'h00)) begin
                miscompares++;
                $display("FAIL single_state got=%h exp=%h", State_q, (rep == 0) ? 8'h0F : 8'h00);
            end
        end
    endtask

    task automatic test_all();
        int   order[$];
        int   scyc[$];
        logic prev_en;
        do_reset();
        prev_en = 1'b0;
        Req = 4'b1111;
        Mask = {8'h08, 8'h04, 8'h02, 8'h01};
        for (int c = 0; c < 24; c++) begin
            tick();
            vectors++;
            if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== exp_all()) begin
                miscompares++;
                $display("FAIL all cyc=%0d got=%h exp=%h", cyc, {Gnt, Ack, T_out, En_out, State_q, Busy}, exp_all());
            end
            vectors++;
            if (prev_en && En_out) begin
                miscompares++;
                $display("FAIL all_double_en cyc=%0d got=1 exp=0", cyc);
            end
            prev_en = En_out;
            if (En_out) begin
                order.push_back(oh_index(Ack));
                scyc.push_back(cyc);
                Req = Req & ~Ack;
            end
        end
        vectors++;
        if (order.size() != 4) begin
            miscompares++;
            $display("FAIL all_count got=%0d exp=4", order.size());
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            vectors++;
            if (order[i] != i || (i > 0 && scyc[i] - scyc[i-1] != ST + 2)) begin
                miscompares++;
                $display("FAIL all_order idx=%0d got=%0d exp=%0d", i, order[i], i);
            end
        end
        vectors++;
        if (State_q !== 8'h0F) begin
            miscompares++;
            $display("FAIL all_state got=%h exp=0f", State_q);
        end
    endtask

    task automatic test_fairness();
        int order[$];
        int exp_o[4];
        exp_o = '{0, 2, 0, 2};
        do_reset();
        Req = 4'b0101;
        Mask = $urandom;
        Mask[0 +: W] = 8'h80;
        Mask[2*W +: W] = 8'h01;
        for (int c = 0; c < 24; c++) begin
            tick();
            vectors++;
            if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== exp_all()) begin
                miscompares++;
                $display("FAIL fair cyc=%0d got=%h exp=%h", cyc, {Gnt, Ack, T_out, En_out, State_q, Busy}, exp_all());
            end
            if (En_out) begin
                order.push_back(oh_index(Ack));
                if (order.size() == 4) Req = '0;
            end
        end
        vectors++;
        if (order.size() != 4) begin
            miscompares++;
            $display("FAIL fair_count got=%0d exp=4", order.size());
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            vectors++;
            if (order[i] != exp_o[i]) begin
                miscompares++;
                $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i, order[i], exp_o[i]);
            end
        end
        vectors++;
        if (State_q !== 8'h00) begin
            miscompares++;
            $display("FAIL fair_state got=%h exp=00", State_q);
        end
    endtask

    task automatic test_commit();
        int en_cnt;
        do_reset();
        Req = 4'b1000;
        Mask = '0;
        Mask[3*W +: W] = 8'h55;
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++;
            if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== exp_all()) begin
                miscompares++;
                $display("FAIL commit cyc=%0d got=%h exp=%h", cyc, {Gnt, Ack, T_out, En_out, State_q, Busy}, exp_all());
            end
            if (En_out) begin
                vectors++;
                if (T_out !== 8'h55) begin
                    miscompares++;
                    $display("FAIL commit_tout got=%h exp=55", T_out);
                end
                Mask[3*W +: W] = 8'hAA;
                Req = '0;
            end
        end
        vectors++;
        if (State_q !== 8'h55) begin
            miscompares++;
            $display("FAIL commit_state got=%h exp=55", State_q);
        end
        en_cnt = 0;
        Req = 4'b1000;
        Mask[3*W +: W] = 8'h00;
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++;
            if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== exp_all()) begin
                miscompares++;
                $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, {Gnt, Ack, T_out, En_out, State_q, Busy}, exp_all());
            end
            if (En_out) begin
                en_cnt++;
                vectors++;
                if (Ack !== 4'b1000 || T_out !== 8'h00) begin
                    miscompares++;
                    $display("FAIL zero_strobe got=%h exp=%h", {Ack, T_out}, {4'b1000, 8'h00});
                end
                Req = '0;
            end
        end
        vectors++;
        if (en_cnt != 1 || State_q !== 8'h55) begin
            miscompares++;
            $display("FAIL zero_state got=%0d/%h exp=1/55", en_cnt, State_q);
        end
    endtask

    task automatic test_ptr_reset();
        logic seen;
        do_reset();
        seen = 1'b0;
        Req = 4'b0100;
        Mask = $urandom;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            if (Ack[2]) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL ptr_first_grant got=0 exp=1");
        end
        tick();
        Rst_n = 1'b0;
        model_reset();
        tick();
        Rst_n = 1'b1;
        Req = 4'b1111;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            if (En_out) begin
                seen = 1'b1;
                vectors++;
                if (Ack !== 4'b0001 || Gnt !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL ptr_after_reset got=%b exp=0001", Ack);
                end
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL ptr_timeout got=0 exp=1");
        end
        Req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            Req  = (Req & ~Ack) | N'($urandom_range(0, 15) & $urandom_range(0, 15));
            Mask = $urandom;
            tick();
            vectors++;
            if ({Gnt, Ack, T_out, En_out, State_q, Busy} !== exp_all()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {Gnt, Ack, T_out, En_out, State_q, Busy}, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_fairness();
        test_commit();
        test_ptr_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
